zx81_kbd_matrix: RTL and testbench

ZX81_KBD_MATRIX -- requirements
Module: zx81_kbd_matrix

---
 rtl/zx81_kbd_pkg.sv | 92 +++++++++
 rtl/zx81_kbd_decode.sv | 87 ++++++++
 rtl/zx81_kbd_matrix.sv | 187 ++++++++++++++++++
 tb/tb_zx81_kbd_matrix.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/zx81_kbd_pkg.sv
// Shared definitions for the ZX81 keyboard matrix: PS/2 set-2 scancodes,
// composite-key FSM states and the decoded key record.
package zx81_kbd_pkg;

    localparam int unsigned NUM_ROWS = 8;
    localparam int unsigned NUM_COLS = 5;
    localparam int unsigned ROW_W    = 3;
    localparam int unsigned COL_W    = 3;

    // Direct keys, grouped by ZX81 row (col0 first)
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_Z      = 8'h1A;
    localparam logic [7:0] SC_X      = 8'h22;
    localparam logic [7:0] SC_C      = 8'h21;
    localparam logic [7:0] SC_V      = 8'h2A;

    localparam logic [7:0] SC_A      = 8'h1C;
    localparam logic [7:0] SC_S      = 8'h1B;
    localparam logic [7:0] SC_D      = 8'h23;
    localparam logic [7:0] SC_F      = 8'h2B;
    localparam logic [7:0] SC_G      = 8'h34;

    localparam logic [7:0] SC_Q      = 8'h15;
    localparam logic [7:0] SC_W      = 8'h1D;
    localparam logic [7:0] SC_E      = 8'h24;
    localparam logic [7:0] SC_R      = 8'h2D;
    localparam logic [7:0] SC_T      = 8'h2C;

    localparam logic [7:0] SC_1      = 8'h16;
    localparam logic [7:0] SC_2      = 8'h1E;
    localparam logic [7:0] SC_3      = 8'h26;
    localparam logic [7:0] SC_4      = 8'h25;
    localparam logic [7:0] SC_5      = 8'h2E;

    localparam logic [7:0] SC_0      = 8'h45;
    localparam logic [7:0] SC_9      = 8'h46;
    localparam logic [7:0] SC_8      = 8'h3E;
    localparam logic [7:0] SC_7      = 8'h3D;
    localparam logic [7:0] SC_6      = 8'h36;

    localparam logic [7:0] SC_P      = 8'h4D;
    localparam logic [7:0] SC_O      = 8'h44;
    localparam logic [7:0] SC_I      = 8'h43;
    localparam logic [7:0] SC_U      = 8'h3C;
    localparam logic [7:0] SC_Y      = 8'h35;

    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_L      = 8'h4B;
    localparam logic [7:0] SC_K      = 8'h42;
    localparam logic [7:0] SC_J      = 8'h3B;
    localparam logic [7:0] SC_H      = 8'h33;

    localparam logic [7:0] SC_SPACE  = 8'h29;
    localparam logic [7:0] SC_DOT    = 8'h49;
    localparam logic [7:0] SC_M      = 8'h3A;
    localparam logic [7:0] SC_N      = 8'h31;
    localparam logic [7:0] SC_B      = 8'h32;

    // Composite keys (SHIFT + digit); arrows carry the E0 prefix
    localparam logic [7:0] SC_BKSP     = 8'h66;
    localparam logic [7:0] SC_E0_LEFT  = 8'h6B;
    localparam logic [7:0] SC_E0_DOWN  = 8'h72;
    localparam logic [7:0] SC_E0_UP    = 8'h75;
    localparam logic [7:0] SC_E0_RIGHT = 8'h74;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_HOLD = 2'd2,
        ST_POST = 2'd3
    } comp_state_e;

    typedef struct packed {
        logic             valid;
        logic             composite;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } key_dec_t;

    // Build a valid decode record for a matrix position
    function automatic key_dec_t key_at(input int unsigned row, input int unsigned col,
                                        input logic composite);
        key_dec_t d;
        d.valid     = 1'b1;
        d.composite = composite;
        d.row       = ROW_W'(row);
        d.col       = COL_W'(col);
        return d;
    endfunction

endpackage

// File: rtl/zx81_kbd_decode.sv
// Combinational PS/2 set-2 scancode -> ZX81 matrix position lookup.
// Ports: ext/code in (E0 flag + scancode); valid_c, composite_c, row_c, col_c out.
// Composite keys decode only when ZX81_KBD_COMPOSITE_EN is defined,
// otherwise they come back as unmapped.
module zx81_kbd_decode
    import zx81_kbd_pkg::*;
(
    input  logic             ext,
    input  logic [7:0]       code,
    output logic             valid_c,
    output logic             composite_c,
    output logic [ROW_W-1:0] row_c,
    output logic [COL_W-1:0] col_c
);

    key_dec_t dec;

    always_comb begin
        dec = '0;
        if (!ext) begin
            case (code)
                SC_LSHIFT, SC_RSHIFT: dec = key_at(0, 0, 1'b0);
                SC_Z:     dec = key_at(0, 1, 1'b0);
                SC_X:     dec = key_at(0, 2, 1'b0);
                SC_C:     dec = key_at(0, 3, 1'b0);
                SC_V:     dec = key_at(0, 4, 1'b0);
                SC_A:     dec = key_at(1, 0, 1'b0);
                SC_S:     dec = key_at(1, 1, 1'b0);
                SC_D:     dec = key_at(1, 2, 1'b0);
                SC_F:     dec = key_at(1, 3, 1'b0);
                SC_G:     dec = key_at(1, 4, 1'b0);
                SC_Q:     dec = key_at(2, 0, 1'b0);
                SC_W:     dec = key_at(2, 1, 1'b0);
                SC_E:     dec = key_at(2, 2, 1'b0);
                SC_R:     dec = key_at(2, 3, 1'b0);
                SC_T:     dec = key_at(2, 4, 1'b0);
                SC_1:     dec = key_at(3, 0, 1'b0);
                SC_2:     dec = key_at(3, 1, 1'b0);
                SC_3:     dec = key_at(3, 2, 1'b0);
                SC_4:     dec = key_at(3, 3, 1'b0);
                SC_5:     dec = key_at(3, 4, 1'b0);
                SC_0:     dec = key_at(4, 0, 1'b0);
                SC_9:     dec = key_at(4, 1, 1'b0);
                SC_8:     dec = key_at(4, 2, 1'b0);
                SC_7:     dec = key_at(4, 3, 1'b0);
                SC_6:     dec = key_at(4, 4, 1'b0);
                SC_P:     dec = key_at(5, 0, 1'b0);
                SC_O:     dec = key_at(5, 1, 1'b0);
                SC_I:     dec = key_at(5, 2, 1'b0);
                SC_U:     dec = key_at(5, 3, 1'b0);
                SC_Y:     dec = key_at(5, 4, 1'b0);
                SC_ENTER: dec = key_at(6, 0, 1'b0);
                SC_L:     dec = key_at(6, 1, 1'b0);
                SC_K:     dec = key_at(6, 2, 1'b0);
                SC_J:     dec = key_at(6, 3, 1'b0);
                SC_H:     dec = key_at(6, 4, 1'b0);
                SC_SPACE: dec = key_at(7, 0, 1'b0);
                SC_DOT:   dec = key_at(7, 1, 1'b0);
                SC_M:     dec = key_at(7, 2, 1'b0);
                SC_N:     dec = key_at(7, 3, 1'b0);
                SC_B:     dec = key_at(7, 4, 1'b0);
`ifdef ZX81_KBD_COMPOSITE_EN
                SC_BKSP:  dec = key_at(4, 0, 1'b1);
`endif
                default:  dec = '0;
            endcase
        end
`ifdef ZX81_KBD_COMPOSITE_EN
        else begin
            // E0-12 (fake shift) and all other extended codes stay unmapped
            case (code)
                SC_E0_LEFT:  dec = key_at(3, 4, 1'b1);
                SC_E0_DOWN:  dec = key_at(4, 4, 1'b1);
                SC_E0_UP:    dec = key_at(4, 3, 1'b1);
                SC_E0_RIGHT: dec = key_at(4, 2, 1'b1);
                default:     dec = '0;
            endcase
        end
`endif
    end

    assign valid_c     = dec.valid;
    assign composite_c = dec.composite;
    assign row_c       = dec.row;
    assign col_c       = dec.col;

endmodule

// File: rtl/zx81_kbd_matrix.sv
// PS/2 key events -> ZX81 8x5 keyboard matrix as seen by the ULA port.
// Ports: clk_sys, reset (sync, active-high), ps2_key[10:0] event word,
//        row_sel[7:0] active-low row selects (A15..A8), col_out[4:0]
//        active-low column return, kbd_busy (composite sequence running).
// Optional feature: ZX81_KBD_COMPOSITE_EN adds the SHIFT+key composite FSM.
module zx81_kbd_matrix
    import zx81_kbd_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 250000,
    parameter int unsigned SHIFT_LEAD  = 12500
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic [7:0]  row_sel,
    output logic [4:0]  col_out,
    output logic        kbd_busy
);

    if (HOLD_CYCLES < 1 || SHIFT_LEAD < 1) begin : g_param_chk
        $error("HOLD_CYCLES and SHIFT_LEAD must be at least 1");
    end

    logic toggle_q, toggle_d, evt_c;
    logic [NUM_ROWS-1:0][NUM_COLS-1:0] matrix_q, matrix_d, overlay_c;
    logic [4:0] col_out_q, col_out_d;
    logic kbd_busy_q, kbd_busy_d;

    logic             dec_valid_c, dec_comp_c;
    logic [ROW_W-1:0] dec_row_c;
    logic [COL_W-1:0] dec_col_c;

    zx81_kbd_decode u_decode (
        .ext         (ps2_key[8]),
        .code        (ps2_key[7:0]),
        .valid_c     (dec_valid_c),
        .composite_c (dec_comp_c),
        .row_c       (dec_row_c),
        .col_c       (dec_col_c)
    );

    // One event per toggle; reset reloads the copy so nothing fires after it
    assign toggle_d = ps2_key[10];
    assign evt_c    = ps2_key[10] ^ toggle_q;

    // Direct keys update the matrix in every FSM state
    always_comb begin
        matrix_d = matrix_q;
        if (evt_c && dec_valid_c && !dec_comp_c) begin
            matrix_d[dec_row_c][dec_col_c] = ps2_key[9];
        end
    end

    // Column return: any selected row with a key (real or overlaid) pulls low
    always_comb begin
        col_out_d = 5'h1F;
        for (int unsigned r = 0; r < NUM_ROWS; r++) begin
            if (!row_sel[r]) begin
                col_out_d = col_out_d & ~(matrix_q[r] | overlay_c[r]);
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        toggle_q <= toggle_d;
        if (reset) begin
            matrix_q   <= '0;
            col_out_q  <= 5'h1F;
            kbd_busy_q <= 1'b0;
        end else begin
            matrix_q   <= matrix_d;
            col_out_q  <= col_out_d;
            kbd_busy_q <= kbd_busy_d;
        end
    end

`ifdef ZX81_KBD_COMPOSITE_EN
    localparam int unsigned CNT_MAX =
        ((HOLD_CYCLES > SHIFT_LEAD) ? HOLD_CYCLES : SHIFT_LEAD) - 1;
    localparam int unsigned CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

    comp_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rel_pend_q, rel_pend_d;
    logic [8:0]       act_key_q, act_key_d;
    logic [ROW_W-1:0] act_row_q, act_row_d;
    logic [COL_W-1:0] act_col_q, act_col_d;
    logic             press_c, rel_act_c, cnt_zero_c;

    assign press_c    = evt_c && dec_valid_c && dec_comp_c && ps2_key[9];
    assign rel_act_c  = evt_c && dec_valid_c && dec_comp_c && !ps2_key[9]
                        && (ps2_key[8:0] == act_key_q);
    assign cnt_zero_c = (cnt_q == '0);

    // State register
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rel_pend_q <= 1'b0;
            act_key_q  <= '0;
            act_row_q  <= '0;
            act_col_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rel_pend_q <= rel_pend_d;
            act_key_q  <= act_key_d;
            act_row_q  <= act_row_d;
            act_col_q  <= act_col_d;
        end
    end

    // Next state; the counter reloads on every state entry so it never wraps
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rel_pend_d = rel_pend_q;
        act_key_d  = act_key_q;
        act_row_d  = act_row_q;
        act_col_d  = act_col_q;
        case (state_q)
            ST_IDLE: begin
                if (press_c) begin
                    state_d    = ST_PRE;
                    cnt_d      = CNT_W'(SHIFT_LEAD - 1);
                    rel_pend_d = 1'b0;
                    act_key_d  = ps2_key[8:0];
                    act_row_d  = dec_row_c;
                    act_col_d  = dec_col_c;
                end
            end
            ST_PRE: begin
                if (rel_act_c) rel_pend_d = 1'b1;
                if (cnt_zero_c) begin
                    state_d = ST_HOLD;
                    cnt_d   = CNT_W'(HOLD_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (rel_act_c) rel_pend_d = 1'b1;
                // Counter parks at zero until the release has been seen
                if (cnt_zero_c && (rel_pend_q || rel_act_c)) begin
                    state_d    = ST_POST;
                    cnt_d      = CNT_W'(SHIFT_LEAD - 1);
                    rel_pend_d = 1'b0;
                end else if (!cnt_zero_c) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_POST: begin
                if (cnt_zero_c) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: SHIFT overlay around the composite, key overlay during HOLD
    always_comb begin
        overlay_c  = '0;
        kbd_busy_d = (state_d != ST_IDLE);
        case (state_q)
            ST_PRE, ST_POST: overlay_c[0][0] = 1'b1;
            ST_HOLD: begin
                overlay_c[0][0]                 = 1'b1;
                overlay_c[act_row_q][act_col_q] = 1'b1;
            end
            default: ;
        endcase
    end
`else
    always_comb begin
        overlay_c  = '0;
        kbd_busy_d = 1'b0;
    end
`endif

    assign col_out  = col_out_q;
    assign kbd_busy = kbd_busy_q;

endmodule

// File: tb/tb_zx81_kbd_matrix.sv
// Self-checking bench for zx81_kbd_matrix: directed scenarios plus random
// key/row traffic, every cycle compared against a timeline-based model.
// Follows ZX81_KBD_COMPOSITE_EN the same way the design does.
module tb_zx81_kbd_matrix;

    localparam int HC = 20;
    localparam int SL = 4;
`ifdef ZX81_KBD_COMPOSITE_EN
    localparam bit COMP_EN = 1'b1;
`else
    localparam bit COMP_EN = 1'b0;
`endif

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [10:0] ps2_key;
    logic [7:0]  row_sel;
    logic [4:0]  col_out;
    logic        kbd_busy;

    zx81_kbd_matrix #(.HOLD_CYCLES(HC), .SHIFT_LEAD(SL)) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .ps2_key  (ps2_key),
        .row_sel  (row_sel),
        .col_out  (col_out),
        .kbd_busy (kbd_busy)
    );

    always #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    // ZX81 layout as rows of scancodes; composites as SHIFT + digit
    byte unsigned key_tab [8][5];
    logic [8:0]   comp_code [5];
    int           comp_digit [5];

    // Model: key matrix plus composite timeline (press edge, release edge)
    logic [7:0][4:0] m_mat = '0;
    logic            m_tog = 1'b0;
    int              cyc = 0;
    int              k_start = -1;
    int              r_rel = -1;
    int              act_row = 0, act_col = 0;
    logic [8:0]      act_key = '0;

    int   cnt_bit = -1;
    int   low_cnt, busy_cnt, episodes;
    logic prev_bit;

    function automatic void digit_pos(input int d, output int r, output int c);
        if (d >= 1 && d <= 5) begin r = 3; c = d - 1; end
        else begin r = 4; c = (d == 0) ? 0 : 10 - d; end
    endfunction

    function automatic void ref_decode(input logic [8:0] code, output bit valid,
                                       output bit comp, output int r, output int c);
        valid = 0; comp = 0; r = 0; c = 0;
        if (code == 9'h059) valid = 1;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 5; j++)
                if (code == {1'b0, key_tab[i][j]}) begin valid = 1; r = i; c = j; end
        if (COMP_EN)
            for (int q = 0; q < 5; q++)
                if (code == comp_code[q]) begin
                    valid = 1; comp = 1; digit_pos(comp_digit[q], r, c);
                end
    endfunction

    // 0 idle, 1 shift lead-in, 2 shift+key hold, 3 shift lead-out (state after edge n)
    function automatic int phase_at(input int n);
        int e;
        if (k_start < 0 || n < k_start) return 0;
        if (n < k_start + SL) return 1;
        if (r_rel < 0) return 2;
        e = (r_rel > k_start + SL + HC) ? r_rel : k_start + SL + HC;
        if (n < e) return 2;
        if (n < e + SL) return 3;
        return 0;
    endfunction

    task automatic tick();
        logic [10:0]     k;
        logic [7:0]      rs;
        logic            rst;
        logic [4:0]      exp_col;
        logic [7:0][4:0] ov;
        bit              v, cp;
        int              r, c, n, ph_prev;
        k = ps2_key; rs = row_sel; rst = reset;
        @(posedge clk_sys);
        cyc++;
        n = cyc;
        if (rst) begin
            m_mat = '0; k_start = -1; r_rel = -1; m_tog = k[10];
            exp_col = 5'h1F;
        end else begin
            ph_prev = phase_at(n - 1);
            ov = '0;
            if (ph_prev != 0) ov[0][0] = 1'b1;
            if (ph_prev == 2) ov[act_row][act_col] = 1'b1;
            exp_col = 5'h1F;
            for (int i = 0; i < 8; i++)
                if (!rs[i]) exp_col &= ~(m_mat[i] | ov[i]);
            if (k[10] != m_tog) begin
                m_tog = k[10];
                ref_decode(k[8:0], v, cp, r, c);
                if (v && !cp) m_mat[r][c] = k[9];
                else if (v && cp) begin
                    if (k[9] && ph_prev == 0) begin
                        k_start = n; r_rel = -1; act_key = k[8:0]; act_row = r; act_col = c;
                    end else if (!k[9] && k[8:0] == act_key && (ph_prev == 1 || ph_prev == 2)
                                 && r_rel < 0) begin
                        r_rel = n;
                    end
                end
            end
        end
        #1;
        check($sformatf("col_out@%0d", n), 32'(col_out), 32'(exp_col));
        check($sformatf("kbd_busy@%0d", n), 32'(kbd_busy), 32'(phase_at(n) != 0));
        if (cnt_bit >= 0) begin
            if (col_out[cnt_bit] == 1'b0) begin
                low_cnt++;
                if (prev_bit) episodes++;
            end
            if (kbd_busy) busy_cnt++;
            prev_bit = col_out[cnt_bit];
        end
    endtask

    task automatic send(input logic pressed, input logic [8:0] code);
        ps2_key = {~ps2_key[10], pressed, code};
        tick();
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic start_count(input int b);
        cnt_bit = b; low_cnt = 0; busy_cnt = 0; episodes = 0; prev_bit = 1'b1;
    endtask

    initial begin
        logic [8:0] code;
        int sel;
        key_tab = '{'{8'h12, 8'h1A, 8'h22, 8'h21, 8'h2A},
                    '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34},
                    '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C},
                    '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E},
                    '{8'h45, 8'h46, 8'h3E, 8'h3D, 8'h36},
                    '{8'h4D, 8'h44, 8'h43, 8'h3C, 8'h35},
                    '{8'h5A, 8'h4B, 8'h42, 8'h3B, 8'h33},
                    '{8'h29, 8'h49, 8'h3A, 8'h31, 8'h32}};
        comp_code  = '{9'h066, 9'h16B, 9'h172, 9'h175, 9'h174};
        comp_digit = '{0, 5, 6, 7, 8};

        ps2_key = '0; row_sel = 8'hFF; reset = 1'b1;
        idle(2);
        check("reset_col", 32'(col_out), 32'h1F);
        check("reset_busy", 32'(kbd_busy), 32'h0);
        reset = 1'b0;
        idle(1);

        // A on row1
        row_sel = 8'hFD; idle(1);
        send(1'b1, 9'h01C); tick();
        check("a_press", 32'(col_out), 32'h1E);
        send(1'b0, 9'h01C); tick();
        check("a_release", 32'(col_out), 32'h1F);

        // SHIFT + Z on row0, then an unrelated row
        send(1'b1, 9'h012); send(1'b1, 9'h01A);
        row_sel = 8'hFE; tick();
        check("shift_z_row0", 32'(col_out), 32'h1C);
        row_sel = 8'h7F; tick();
        check("shift_z_row7", 32'(col_out), 32'h1F);
        send(1'b0, 9'h012); send(1'b0, 9'h01A);

        // Backspace: SHIFT lead-in, hold, lead-out as seen on row0
        row_sel = 8'hFE; idle(2);
        start_count(0);
        send(1'b1, 9'h066); send(1'b0, 9'h066); idle(40);
        check("bksp_row0_low", 32'(low_cnt), COMP_EN ? 32'd28 : 32'd0);
        check("bksp_busy", 32'(busy_cnt), COMP_EN ? 32'd28 : 32'd0);

        // Same sequence seen on row4 (the '0' key only during hold)
        row_sel = 8'hEF; idle(2);
        start_count(0);
        send(1'b1, 9'h066); send(1'b0, 9'h066); idle(40);
        check("bksp_row4_low", 32'(low_cnt), COMP_EN ? 32'd20 : 32'd0);
        cnt_bit = -1;

        // Repeat press during hold is dropped; direct Q still works
        row_sel = 8'hF3; idle(2);
        start_count(4);
        send(1'b1, 9'h16B); idle(SL + 3);
        send(1'b1, 9'h16B); send(1'b0, 9'h16B);
        send(1'b1, 9'h015); tick();
        check("q_during_hold", 32'(col_out[0]), 32'h0);
        idle(40);
        send(1'b0, 9'h015); idle(2);
        check("left_one_episode", 32'(episodes), COMP_EN ? 32'd1 : 32'd0);
        cnt_bit = -1;

        // Reset in the middle of a hold
        row_sel = 8'h00;
        send(1'b1, 9'h066); idle(SL + 3);
        reset = 1'b1; tick();
        check("midseq_rst_col", 32'(col_out), 32'h1F);
        check("midseq_rst_busy", 32'(kbd_busy), 32'h0);
        reset = 1'b0; idle(3);
        check("post_rst_col", 32'(col_out), 32'h1F);
        check("post_rst_busy", 32'(kbd_busy), 32'h0);

        // Backspace swept across every row_sel value
        send(1'b1, 9'h066); send(1'b0, 9'h066);
        for (int i = 0; i < 256; i++) begin
            row_sel = 8'(i);
            tick();
        end

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            row_sel = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 5) == 0) begin
                sel = $urandom_range(0, 9);
                if (sel < 6) code = {1'b0, key_tab[$urandom_range(0, 7)][$urandom_range(0, 4)]};
                else if (sel < 8) code = comp_code[$urandom_range(0, 4)];
                else if (sel == 8) code = 9'h059;
                else code = 9'($urandom_range(0, 511));
                send(1'($urandom_range(0, 1)), code);
            end else begin
                tick();
            end
            reset = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
